// File: rtl/dmem_arbiter.sv
// Two-port (CPU / debug) arbiter with fixed wait states in front of one DataMemory port.
// Optional DMEM_ARB_LOCK_EN lets the debug port hold ownership for up to LOCK_MAX extra grants.
module dmem_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int WAIT_CYCLES = 2,
  parameter int LOCK_MAX    = 4
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_done,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner
);

  // state  | meaning
  // IDLE   | no transfer; arbitration and grant happen here
  // ACCESS | transfer in flight for WAIT_CYCLES cycles
  // DONE   | one-cycle completion pulse to the owning port
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              last_grant;
  logic              owner_q;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
  logic              grant, grant_port, last_cycle;

`ifdef DMEM_ARB_LOCK_EN
  localparam int              LC_W       = $clog2(LOCK_MAX + 1);
  localparam logic [LC_W-1:0] LOCK_LIMIT = LC_W'(LOCK_MAX);
  logic [LC_W-1:0] lock_cnt;
  logic            lock_pend;
`else
  logic unused_lock;
  assign unused_lock = dbg_lock ^ (LOCK_MAX == 0);
`endif

  assign last_cycle = (state == ACCESS) && (cnt == 4'd0);

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    grant_port = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          grant     = 1'b1;
          state_nxt = ACCESS;
          if (cpu_req && dbg_req) begin
`ifdef DMEM_ARB_LOCK_EN
            if (lock_pend) grant_port = (lock_cnt < LOCK_LIMIT);
            else           grant_port = ~last_grant;
`else
            grant_port = ~last_grant;
`endif
          end else begin
            grant_port = dbg_req;
          end
        end
      end
      ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      cnt         <= 4'd0;
      last_grant  <= 1'b1;
      owner_q     <= 1'b0;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      if (grant) begin
        owner_q    <= grant_port;
        last_grant <= grant_port;
        lat_we     <= grant_port ? dbg_we    : cpu_we;
        lat_addr   <= grant_port ? dbg_addr  : cpu_addr;
        lat_wdata  <= grant_port ? dbg_wdata : cpu_wdata;
        cnt        <= CNT_LOAD;
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // Writes leave the port's read register untouched.
      if (last_cycle && !lat_we) begin
        if (owner_q) dbg_rdata_q <= mem_rdata;
        else         cpu_rdata_q <= mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_LOCK_EN
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      lock_cnt  <= '0;
      lock_pend <= 1'b0;
    end else begin
      if (grant) begin
        lock_pend <= 1'b0;
        if (!grant_port)                              lock_cnt <= '0;
        else if (lock_pend && lock_cnt < LOCK_LIMIT) lock_cnt <= lock_cnt + 1'b1;
      end
      if (state == DONE) lock_pend <= owner_q && dbg_lock && dbg_req;
    end
  end
`endif

  assign cpu_done  = (state == DONE) && !owner_q;
  assign dbg_done  = (state == DONE) &&  owner_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign cpu_stall = cpu_req & ~cpu_done;
  assign mem_addr  = (state == ACCESS) ? lat_addr  : '0;
  assign mem_wdata = (state == ACCESS) ? lat_wdata : '0;
  assign mem_rd    = (state == ACCESS) && !lat_we;
  assign mem_wr    = last_cycle && lat_we;
  assign owner     = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random two-port traffic against a
// transaction-level model (countdown to completion, round-robin pick, reference memory).
module tb_dmem_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int WC = 2;

  logic          CLK = 1'b0;
  logic          resetl = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          cpu_done, cpu_stall, dbg_done, mem_rd, mem_wr, owner;
  logic [DW-1:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC), .LOCK_MAX(4)) dut (
    .CLK(CLK), .resetl(resetl),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  function automatic logic [63:0] init_word(input int i);
    return (i == 2) ? 64'hDEAD : 64'h0F00_0000_0000_0000 + 64'(i) * 64'h0101_0101;
  endfunction

  // DataMemory stand-in: 16 words, address bits [6:3].
  logic [63:0] dmem [0:15];
  bit mem_ready = 1'b0;
  always @(posedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 16; i++) dmem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (mem_wr) begin
      dmem[mem_addr[6:3]] <= mem_wdata;
    end
  end
  assign mem_rdata = dmem[mem_addr[6:3]];

  int wr_edges = 0, wr_cycles = 0, cpu_done_edges = 0;
  always @(posedge mem_wr)  wr_edges <= wr_edges + 1;
  always @(posedge cpu_done) cpu_done_edges <= cpu_done_edges + 1;
  always @(negedge CLK) if (mem_wr) wr_cycles <= wr_cycles + 1;

  // Reference model: m_rem counts cycles until the arbiter is free again
  // (WC+1 at grant: WC access cycles, then the done cycle).
  int          m_rem = 0;
  bit          m_owner = 1'b0, m_last = 1'b1, m_we = 1'b0;
  logic [63:0] m_addr = '0, m_wdata = '0, m_cpu_rdata = '0, m_dbg_rdata = '0;
  logic [63:0] ref_mem [0:15];
  bit          ref_ready = 1'b0;
  wire         m_pick = (cpu_req && dbg_req) ? !m_last : dbg_req;

  always @(posedge CLK or negedge resetl) begin
    if (!ref_ready) begin
      for (int i = 0; i < 16; i++) ref_mem[i] <= init_word(i);
      ref_ready <= 1'b1;
    end
    if (!resetl) begin
      m_rem <= 0; m_owner <= 1'b0; m_last <= 1'b1;
      m_cpu_rdata <= '0; m_dbg_rdata <= '0;
    end else if (m_rem == 0) begin
      if (cpu_req || dbg_req) begin
        m_owner <= m_pick;
        m_last  <= m_pick;
        m_rem   <= WC + 1;
        m_we    <= m_pick ? dbg_we    : cpu_we;
        m_addr  <= m_pick ? dbg_addr  : cpu_addr;
        m_wdata <= m_pick ? dbg_wdata : cpu_wdata;
      end
    end else begin
      m_rem <= m_rem - 1;
      if (m_rem == 2) begin
        if (m_we)         ref_mem[m_addr[6:3]] <= m_wdata;
        else if (m_owner) m_dbg_rdata <= ref_mem[m_addr[6:3]];
        else              m_cpu_rdata <= ref_mem[m_addr[6:3]];
      end
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle_check();
    bit ecd, edd;
    ecd = (m_rem == 1) && !m_owner;
    edd = (m_rem == 1) &&  m_owner;
    check_val("cpu_done",  cpu_done,  ecd);
    check_val("dbg_done",  dbg_done,  edd);
    check_val("cpu_rdata", cpu_rdata, m_cpu_rdata);
    check_val("dbg_rdata", dbg_rdata, m_dbg_rdata);
    check_val("owner",     owner,     m_owner);
    check_val("mem_rd",    mem_rd,    (m_rem >= 2) && !m_we);
    check_val("mem_wr",    mem_wr,    (m_rem == 2) && m_we);
    check_val("cpu_stall", cpu_stall, cpu_req && !ecd);
    if (m_rem >= 2) begin
      check_val("mem_addr", mem_addr, m_addr);
      if (m_we) check_val("mem_wdata", mem_wdata, m_wdata);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
    if (resetl) cycle_check();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tg);
    check_val({tg, "_cpu_done"},  cpu_done,  0);
    check_val({tg, "_dbg_done"},  dbg_done,  0);
    check_val({tg, "_cpu_rdata"}, cpu_rdata, 0);
    check_val({tg, "_dbg_rdata"}, dbg_rdata, 0);
    check_val({tg, "_mem_addr"},  mem_addr,  0);
    check_val({tg, "_mem_wdata"}, mem_wdata, 0);
    check_val({tg, "_mem_rd"},    mem_rd,    0);
    check_val({tg, "_mem_wr"},    mem_wr,    0);
    check_val({tg, "_owner"},     owner,     0);
  endtask

  task automatic do_reset(input string tg);
    cpu_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0;
    resetl = 1'b0;
    #1;
    check_reset_outputs(tg);
    cyc();
    cyc();
    resetl = 1'b1;
  endtask

  task automatic new_req(input bit p);
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    we = 1'($urandom_range(0, 1));
    a  = 64'($urandom_range(0, 15)) << 3;
    d  = {$urandom, $urandom};
    if (p) begin dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_req = 1'b1; end
    else   begin cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1; end
  endtask

  task automatic drive_port(input bit p);
    bit busy, fin, req;
    busy = (m_rem >= 2) && (m_owner == p);
    fin  = (m_rem == 1) && (m_owner == p);
    req  = p ? dbg_req : cpu_req;
    if (fin) begin
      if ($urandom_range(0, 1) == 1) new_req(p);
      else if (p) dbg_req = 1'b0;
      else        cpu_req = 1'b0;
    end else if (busy) begin
      // In-flight transfer must ignore any change on its requester's inputs.
      if ($urandom_range(0, 1) == 1) begin
        new_req(p);
        if (!req) begin
          if (p) dbg_req = 1'b0; else cpu_req = 1'b0;
        end
      end
      if ($urandom_range(0, 7) == 0) begin
        if (p) dbg_req = 1'b0; else cpu_req = 1'b0;
      end
    end else if (!req && $urandom_range(0, 2) == 0) begin
      new_req(p);
    end
  endtask

  initial begin
    int we0, wc0, cd0, n;
    #2;
    do_reset("rst0");

    // CPU read of 0x10: done three cycles after the request, stall until then.
    cpu_we = 1'b0; cpu_addr = 64'h10; cpu_req = 1'b1;
    #1;
    check_val("t1_stall_req", cpu_stall, 1);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      check_val("t1_done",  cpu_done,  64'(k == 3));
      check_val("t1_stall", cpu_stall, 64'(k != 3));
    end
    check_val("t1_rdata", cpu_rdata, 64'hDEAD);
    cpu_req = 1'b0;
    cyc();

    // Debug write of 0x1234 to 0x20, then CPU reads it back.
    we0 = wr_edges; wc0 = wr_cycles;
    dbg_we = 1'b1; dbg_addr = 64'h20; dbg_wdata = 64'h1234; dbg_req = 1'b1;
    repeat (3) cyc();
    check_val("t2_dbg_done", dbg_done, 1);
    dbg_req = 1'b0; dbg_we = 1'b0;
    cyc();
    check_val("t2_wr_edges",  64'(wr_edges - we0),  1);
    check_val("t2_wr_cycles", 64'(wr_cycles - wc0), 1);
    cpu_we = 1'b0; cpu_addr = 64'h20; cpu_req = 1'b1;
    repeat (3) cyc();
    check_val("t2_cpu_done",  cpu_done,  1);
    check_val("t2_cpu_rdata", cpu_rdata, 64'h1234);
    cpu_req = 1'b0;
    cyc();

    // Both ports requesting from reset: strict alternation starting with the CPU.
    // dbg_lock is held high and must have no effect in this build.
    do_reset("rst1");
    dbg_lock = 1'b1;
    cpu_we = 1'b0; cpu_addr = 64'h08; cpu_req = 1'b1;
    dbg_we = 1'b0; dbg_addr = 64'h18; dbg_req = 1'b1;
    n = 0;
    for (int k = 0; k < 6 * (WC + 2); k++) begin
      cyc();
      if ((cpu_done || dbg_done) && n < 6) begin
        check_val("t3_owner",    owner,    64'(n % 2));
        check_val("t3_cpu_done", cpu_done, 64'(n % 2 == 0));
        n++;
      end
    end
    check_val("t3_grants", 64'(n), 6);
    cpu_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0;
    cyc();

    // Reset during a CPU write before its strobe: write lost, no done pulse.
    do_reset("rst2");
    we0 = wr_edges; cd0 = cpu_done_edges;
    cpu_we = 1'b1; cpu_addr = 64'h30; cpu_wdata = 64'hBAD0_BAD0; cpu_req = 1'b1;
    cyc();
    check_val("t4_rd_first", mem_rd, 0);
    @(negedge CLK);
    resetl = 1'b0;
    #1;
    check_val("t4_mem_wr",   mem_wr,   0);
    check_val("t4_mem_rd",   mem_rd,   0);
    check_val("t4_cpu_done", cpu_done, 0);
    check_val("t4_owner",    owner,    0);
    @(posedge CLK); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge CLK);
    @(posedge CLK); #1;
    resetl = 1'b1;
    check_val("t4_wr_edges",   64'(wr_edges - we0),       0);
    check_val("t4_done_edges", 64'(cpu_done_edges - cd0), 0);
    cpu_addr = 64'h30; cpu_req = 1'b1;
    repeat (3) cyc();
    check_val("t4_done_after",  cpu_done,  1);
    check_val("t4_rdata_after", cpu_rdata, init_word(6));
    cpu_req = 1'b0;
    cyc();

    // Random two-port traffic against the model.
    do_reset("rst3");
    for (int k = 0; k < 2000; k++) begin
      drive_port(1'b0);
      drive_port(1'b1);
      dbg_lock = 1'($urandom_range(0, 1));
      cyc();
    end

    do_reset("rst4");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
